// File: rtl/if_fetch_pkg.sv
// Shared constants for the fetch stage: reset PC, redirect codes and the
// fetch state encoding. Decode imports the same redirect codes.
package if_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

  typedef enum logic [2:0] {
    J_NONE = 3'd0,
    J_BEQ  = 3'd1,
    J_JAL  = 3'd2,
    J_JR   = 3'd3,
    J_BNE  = 3'd4
  } j_code_e;

  typedef enum logic {
    FETCH = 1'b0,
    FULL  = 1'b1
  } fetch_state_e;

  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_redirect_reg.sv
// Remembers a redirect that arrived before its delay slot was delivered,
// and selects the PC that follows each delivered instruction.
module if_redirect_reg
  import if_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        deliver_i,
  input  logic [2:0]  j_i,
  input  logic [31:0] target_i,
  input  logic [31:0] pc_i,
  output logic [31:0] pc_next_o
);

  logic        redir_vld_q, redir_vld_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic        jump;

  assign jump = (j_i != J_NONE);

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    redir_vld_d = redir_vld_q;
    redir_pc_d  = redir_pc_q;
    pc_next_o   = seq_pc(pc_i);
    if (deliver_i) begin
      redir_vld_d = 1'b0;
      if (jump) begin
        pc_next_o = target_i;
      end else if (redir_vld_q) begin
        pc_next_o = redir_pc_q;
      end
    end else if (jump) begin
      // Delay slot not yet delivered: park the target until it is.
      redir_vld_d = 1'b1;
      redir_pc_d  = target_i;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      redir_vld_q <= 1'b0;
      redir_pc_q  <= '0;
    end else begin
      redir_vld_q <= redir_vld_d;
      redir_pc_q  <= redir_pc_d;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding imem
// request, and loads the IF/ID register (bubble when nothing is ready).
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [2:0]  ID_j_IF,
  input  logic [31:0] ID_pc_IF,
  output logic        IF_imem_req,
  output logic [31:0] IF_imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_instr_ID,
  output logic [31:0] IF_pc_ID,
  output logic        IF_busy
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  buf_q, buf_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc_id_q, pc_id_d;
  logic [31:0]  pc_next;
  logic [31:0]  word;
  logic         avail;
  logic         deliver;

  // Gated by rst so the request is low for the whole reset, not just after.
  assign IF_imem_req  = rst && (state_q == FETCH);
  assign IF_imem_addr = pc_q;
  assign IF_busy      = IF_imem_req;
  assign IF_instr_ID  = instr_q;
  assign IF_pc_ID     = pc_id_q;

  assign avail   = ((state_q == FETCH) && imem_rvalid) || (state_q == FULL);
  assign word    = (state_q == FULL) ? buf_q : imem_rdata;
  assign deliver = avail && !stall;

  if_redirect_reg u_redirect (
    .clk       (clk),
    .rst       (rst),
    .deliver_i (deliver),
    .j_i       (ID_j_IF),
    .target_i  (ID_pc_IF),
    .pc_i      (pc_q),
    .pc_next_o (pc_next)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
    instr_d = instr_q;
    pc_id_d = pc_id_q;

    if (!stall) begin
      instr_d = avail ? word : '0;
      pc_id_d = avail ? pc_q : '0;
    end
    if (deliver) begin
      pc_d = pc_next;
    end

    // rvalid in FULL is a protocol error and falls through untouched.
    case (state_q)
      FETCH: if (imem_rvalid && stall) begin
        state_d = FULL;
        buf_d   = imem_rdata;
      end
      FULL: if (!stall) begin
        state_d = FETCH;
      end
    endcase
  end

  // NOTE: the one-word buffer is reset with everything else; it is a single
  // register, not a memory, so the reset costs nothing and keeps sim X-free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      buf_q   <= '0;
      instr_q <= '0;
      pc_id_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      instr_q <= instr_d;
      pc_id_q <= pc_id_d;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: a variable-latency imem responder, a word-in-hand
// model of the fetch rules checked every cycle, and directed literal checks.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [2:0]  j_code;
  logic [31:0] j_tgt;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr_id;
  logic [31:0] pc_id;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int lat    = 0;

  always #5 clk = ~clk;

  if_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .ID_j_IF      (j_code),
    .ID_pc_IF     (j_tgt),
    .IF_imem_req  (imem_req),
    .IF_imem_addr (imem_addr),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .IF_instr_ID  (instr_id),
    .IF_pc_ID     (pc_id),
    .IF_busy      (busy)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'hC0DE_0000 | {16'h0, a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Imem: waits 'lat' idle cycles after seeing a request, then one rvalid.
  bit outstanding = 1'b0;
  int wait_cnt    = 0;
  initial forever begin
    @(posedge clk);
    #1;
    if (!rst) begin
      outstanding = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end else if (outstanding || imem_req) begin
      if (!outstanding) begin
        outstanding = 1'b1;
        wait_cnt    = 0;
      end
      if (wait_cnt >= lat) begin
        imem_rvalid = 1'b1;
        imem_rdata  = word_at(imem_addr);
        outstanding = 1'b0;
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        wait_cnt++;
      end
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
  end

  // Model: the address being fetched, at most one word in hand, at most one
  // parked redirect target.
  logic [31:0] m_addr, m_instr, m_pc, held_instr, held_pc, redir_tgt;
  bit          has_held, redir_pend;

  task automatic model_reset();
    m_addr     = 32'h0000_3000;
    m_instr    = '0;
    m_pc       = '0;
    has_held   = 1'b0;
    redir_pend = 1'b0;
    held_instr = '0;
    held_pc    = '0;
    redir_tgt  = '0;
  endtask

  task automatic model_edge();
    bit          got;
    logic [31:0] w, wpc;
    got = 1'b0;
    w   = '0;
    wpc = '0;
    if (has_held) begin
      got = 1'b1;
      w   = held_instr;
      wpc = held_pc;
    end else if (imem_rvalid) begin
      got = 1'b1;
      w   = word_at(m_addr);
      wpc = m_addr;
    end
    if (j_code != 3'd0) check("single_redirect", {31'b0, redir_pend}, 32'd0);
    if (!stall) begin
      if (got) begin
        m_instr  = w;
        m_pc     = wpc;
        has_held = 1'b0;
        if (j_code != 3'd0) begin
          m_addr = j_tgt;
        end else if (redir_pend) begin
          m_addr     = redir_tgt;
          redir_pend = 1'b0;
        end else begin
          m_addr = wpc + 32'd4;
        end
      end else begin
        m_instr = '0;
        m_pc    = '0;
        if (j_code != 3'd0) begin
          redir_pend = 1'b1;
          redir_tgt  = j_tgt;
        end
      end
    end else if (got && !has_held) begin
      has_held   = 1'b1;
      held_instr = w;
      held_pc    = wpc;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else      model_edge();
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    logic exp_req;
    @(negedge clk);
    exp_req = rst && !has_held;
    check("cyc_instr", instr_id, m_instr);
    check("cyc_pc", pc_id, m_pc);
    check("cyc_req", {31'b0, imem_req}, {31'b0, exp_req});
    check("cyc_busy", {31'b0, busy}, {31'b0, exp_req});
    if (exp_req) check("cyc_addr", imem_addr, m_addr);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b0;
    stall  = 1'b0;
    j_code = 3'd0;
    j_tgt  = '0;
    lat    = 0;
    #2;
    check("rst_instr", instr_id, 32'h0);
    check("rst_pc", pc_id, 32'h0);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    check("first_req", {31'b0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'h0000_3000);

    // Zero-latency imem: one instruction per cycle.
    tick(); check("z_bubble_pc", pc_id, 32'h0);
    tick(); check("z_pc0", pc_id, 32'h0000_3000);
            check("z_instr0", instr_id, 32'hC0DE_3000);
    tick(); check("z_pc1", pc_id, 32'h0000_3004);
    tick(); check("z_pc2", pc_id, 32'h0000_3008);
    // Branch in decode at 0x3008; delay slot 0x300C ready on the same edge.
    j_code = 3'd1; j_tgt = 32'h0000_3100;
    tick(); check("br_slot_pc", pc_id, 32'h0000_300C);
            check("br_next_addr", imem_addr, 32'h0000_3100);
    j_code = 3'd0;
    tick(); check("br_target_pc", pc_id, 32'h0000_3100);
    lat = 2;

    // Slow imem: two bubbles per instruction, address held while waiting.
    tick(); check("slow_pc0", pc_id, 32'h0000_3104);
    tick(); check("slow_bub1_pc", pc_id, 32'h0);
            check("slow_bub1_instr", instr_id, 32'h0);
            check("slow_addr1", imem_addr, 32'h0000_3108);
    tick(); check("slow_bub2_pc", pc_id, 32'h0);
            check("slow_addr2", imem_addr, 32'h0000_3108);
    tick(); check("slow_pc1", pc_id, 32'h0000_3108);

    // Response arrives under a four-cycle stall: buffered, then delivered.
    stall = 1'b1;
    tick();
    tick();
    tick(); check("stall_req", {31'b0, imem_req}, 32'd0);
            check("stall_hold_pc", pc_id, 32'h0000_3108);
    tick(); check("stall_hold_pc2", pc_id, 32'h0000_3108);
            check("stall_busy", {31'b0, busy}, 32'd0);
    stall = 1'b0;
    tick(); check("unstall_pc", pc_id, 32'h0000_310C);
            check("unstall_instr", instr_id, 32'hC0DE_310C);
            check("no_refetch_addr", imem_addr, 32'h0000_3110);

    // Branch at 0x310C while its delay slot is still pending.
    j_code = 3'd1; j_tgt = 32'h0000_3200;
    tick(); check("pend_bubble_pc", pc_id, 32'h0);
            check("pend_addr", imem_addr, 32'h0000_3110);
    j_code = 3'd0;
    tick();
    tick(); check("pend_slot_pc", pc_id, 32'h0000_3110);
            check("pend_redir_addr", imem_addr, 32'h0000_3200);
    tick();
    tick();
    tick(); check("pend_target_pc", pc_id, 32'h0000_3200);

    // Steer to 0x3040, then reset mid-wait.
    j_code = 3'd3; j_tgt = 32'h0000_3040;
    tick();
    j_code = 3'd0;
    tick();
    tick(); check("jr_slot_pc", pc_id, 32'h0000_3204);
            check("jr_addr", imem_addr, 32'h0000_3040);
    lat = 5;
    tick(); check("wait_req", {31'b0, imem_req}, 32'd1);
            check("wait_addr", imem_addr, 32'h0000_3040);
    @(negedge clk);
    #3 rst = 1'b0;
    #1;
    check("async_instr", instr_id, 32'h0);
    check("async_pc", pc_id, 32'h0);
    check("async_req", {31'b0, imem_req}, 32'd0);
    check("async_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    #3 rst = 1'b1;
    lat = 0;
    #1;
    check("restart_addr", imem_addr, 32'h0000_3000);
    check("restart_req", {31'b0, imem_req}, 32'd1);
    tick(); check("restart_bubble_pc", pc_id, 32'h0);
    tick(); check("restart_pc0", pc_id, 32'h0000_3000);
    tick(); check("restart_pc1", pc_id, 32'h0000_3004);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
